// File: rtl/wb_dsp_bus_master_pkg.sv
// Shared definitions for the DSP Wishbone bus master: error codes, FSM states
// and fixed Wishbone cycle-type encodings.
package wb_dsp_bus_master_pkg;

  // Error codes are also decoded by the algorithm FSM and the slave status register.
  typedef enum logic [1:0] {
    BUS_ERR_NONE    = 2'd0,
    BUS_ERR_WB      = 2'd1,
    BUS_ERR_TIMEOUT = 2'd2,
    BUS_ERR_RETRY   = 2'd3
  } bus_err_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    BACKOFF = 2'd2
  } bus_state_e;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Counter width able to hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_dsp_bus_master.sv
// Wishbone B3 classic-cycle master for single read/write transfers issued by
// the DSP algorithm state machine, with per-attempt timeout, bounded retry on
// wb_rty_i, and a sticky error code.
module wb_dsp_bus_master
  import wb_dsp_bus_master_pkg::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 3
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [aw-1:0] address,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic [1:0]    error_code,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned RW = cnt_width(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  bus_state_e    state_q, state_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [dw-1:0] dat_o_q, dat_o_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          active_q, active_d;
  logic [dw-1:0] data_rd_q, data_rd_d;
  bus_err_e      err_q, err_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_o_q   <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
      data_rd_q <= '0;
      err_q     <= BUS_ERR_NONE;
      retry_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_o_q   <= dat_o_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      active_q  <= active_d;
      data_rd_q <= data_rd_d;
      err_q     <= err_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state and next-output logic; responses are prioritised ack > err > rty.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_o_d   = dat_o_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    active_d  = active_q;
    data_rd_d = data_rd_q;
    err_d     = err_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCESS;
          adr_d    = address;
          dat_o_d  = data_wr;
          sel_d    = selection;
          we_d     = write;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          active_d = 1'b1;
          err_d    = BUS_ERR_NONE;
          retry_d  = '0;
          tmo_d    = '0;
        end
      end

      ACCESS: begin
        if (wb_ack_i) begin
          if (!we_q) begin
            data_rd_d = wb_dat_i;
          end
          state_d  = IDLE;
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          active_d = 1'b0;
        end else if (wb_err_i) begin
          err_d     = BUS_ERR_WB;
          data_rd_d = '0;
          state_d   = IDLE;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          active_d  = 1'b0;
        end else if (wb_rty_i) begin
          if (retry_q < RETRY_MAX) begin
            // Keep cyc to hold the bus; only stb drops for the backoff cycle.
            retry_d = retry_q + 1'b1;
            stb_d   = 1'b0;
            state_d = BACKOFF;
          end else begin
            err_d     = BUS_ERR_RETRY;
            data_rd_d = '0;
            state_d   = IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            active_d  = 1'b0;
          end
        end else if (TIMEOUT != 0) begin
          if (tmo_q == TMO_LAST) begin
            err_d     = BUS_ERR_TIMEOUT;
            data_rd_d = '0;
            state_d   = IDLE;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            active_d  = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      BACKOFF: begin
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = ACCESS;
      end

      default: begin
        state_d  = IDLE;
        cyc_d    = 1'b0;
        stb_d    = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  assign data_rd    = data_rd_q;
  assign active     = active_q;
  assign error_code = err_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_o_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_cti_o   = WB_CTI_CLASSIC;
  assign wb_bte_o   = WB_BTE_LINEAR;

`ifdef SIM
  string state_name;
  // Readable state for waveform debug.
  always_comb state_name = state_q.name();
`endif

endmodule

// File: tb/tb_wb_dsp_bus_master.sv
// Directed self-checking bench for wb_dsp_bus_master. The main instance uses
// TIMEOUT=16; a second instance with TIMEOUT=0 covers the disabled timeout.
module tb_wb_dsp_bus_master;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          start, start_z;
  logic [AW-1:0] address;
  logic [3:0]    selection;
  logic          write;
  logic [DW-1:0] data_wr;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, ack_z, wb_err_i, wb_rty_i;

  logic [DW-1:0] data_rd, data_rd_z;
  logic          active, active_z;
  logic [1:0]    error_code, error_code_z;
  logic [AW-1:0] wb_adr_o, adr_z;
  logic [DW-1:0] wb_dat_o, dat_z;
  logic [3:0]    wb_sel_o, sel_z;
  logic          wb_we_o, we_z, wb_cyc_o, cyc_z, wb_stb_o, stb_z;
  logic [2:0]    wb_cti_o, cti_z;
  logic [1:0]    wb_bte_o, bte_z;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk = ~wb_clk;

  wb_dsp_bus_master #(.dw(DW), .aw(AW), .TIMEOUT(16), .MAX_RETRY(3)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr),
    .data_rd(data_rd), .active(active), .error_code(error_code),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  wb_dsp_bus_master #(.dw(DW), .aw(AW), .TIMEOUT(0), .MAX_RETRY(3)) dut_z (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start_z), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr),
    .data_rd(data_rd_z), .active(active_z), .error_code(error_code_z),
    .wb_adr_o(adr_z), .wb_dat_o(dat_z), .wb_sel_o(sel_z),
    .wb_we_o(we_z), .wb_cyc_o(cyc_z), .wb_stb_o(stb_z),
    .wb_cti_o(cti_z), .wb_bte_o(bte_z), .wb_dat_i(wb_dat_i),
    .wb_ack_i(ack_z), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk);
  endtask

  task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] s);
    start = 1'b1; address = a; write = w; data_wr = d; selection = s;
  endtask

  initial begin
    wb_rst = 1'b1; start = 1'b0; start_z = 1'b0; address = '0; selection = '0;
    write = 1'b0; data_wr = '0; wb_dat_i = '0; wb_ack_i = 1'b0; ack_z = 1'b0;
    wb_err_i = 1'b0; wb_rty_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_err", 64'(error_code), 64'd0);
    check("rst_data_rd", 64'(data_rd), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_we", 64'(wb_we_o), 64'd0);
    check("cti", 64'(wb_cti_o), 64'd0);
    check("bte", 64'(wb_bte_o), 64'd0);
    check("rst_active_z", 64'(active_z), 64'd0);
    wb_rst = 1'b0;
    tick();

    // Zero-wait read
    req(32'h100, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    check("rd_cyc", 64'(wb_cyc_o), 64'd1);
    check("rd_stb", 64'(wb_stb_o), 64'd1);
    check("rd_active", 64'(active), 64'd1);
    check("rd_adr", 64'(wb_adr_o), 64'h100);
    check("rd_we", 64'(wb_we_o), 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE0001;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    check("rd_done_active", 64'(active), 64'd0);
    check("rd_done_cyc", 64'(wb_cyc_o), 64'd0);
    check("rd_data", 64'(data_rd), 64'hCAFE0001);
    check("rd_err", 64'(error_code), 64'd0);

    // Write with 3 wait states
    req(32'h104, 1'b1, 32'h12345678, 4'hF);
    tick();
    start = 1'b0; address = 32'hDEAD; data_wr = 32'h0; write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wr_we", 64'(wb_we_o), 64'd1);
      check("wr_adr", 64'(wb_adr_o), 64'h104);
      check("wr_dat", 64'(wb_dat_o), 64'h12345678);
      check("wr_sel", 64'(wb_sel_o), 64'hF);
      check("wr_active", 64'(active), 64'd1);
      if (i == 3) begin
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF0000;
      end
      tick();
    end
    wb_ack_i = 1'b0;
    check("wr_done_active", 64'(active), 64'd0);
    check("wr_data_rd_held", 64'(data_rd), 64'hCAFE0001);

    // Retry twice, then ack
    req(32'h200, 1'b0, 32'h0, 4'h3);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rty_stb_hi", 64'(wb_stb_o), 64'd1);
      wb_rty_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      check("rty_stb_lo", 64'(wb_stb_o), 64'd0);
      check("rty_cyc_held", 64'(wb_cyc_o), 64'd1);
      check("rty_active", 64'(active), 64'd1);
      check("rty_adr", 64'(wb_adr_o), 64'h200);
      tick();
    end
    check("rty_stb_3rd", 64'(wb_stb_o), 64'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000BEEF;
    tick();
    wb_ack_i = 1'b0;
    check("rty_done_active", 64'(active), 64'd0);
    check("rty_data", 64'(data_rd), 64'hBEEF);
    check("rty_err", 64'(error_code), 64'd0);

    // Four consecutive retries exhaust the budget
    req(32'h300, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_rty_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      check("rtyx_backoff_cyc", 64'(wb_cyc_o), 64'd1);
      tick();
    end
    wb_rty_i = 1'b1;
    tick();
    wb_rty_i = 1'b0;
    check("rtyx_active", 64'(active), 64'd0);
    check("rtyx_cyc", 64'(wb_cyc_o), 64'd0);
    check("rtyx_err", 64'(error_code), 64'd3);
    check("rtyx_data", 64'(data_rd), 64'd0);

    // Timeout after 16 cycles of cyc
    req(32'h400, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("tmo_active", 64'(active), 64'd1);
      tick();
    end
    check("tmo_done_active", 64'(active), 64'd0);
    check("tmo_err", 64'(error_code), 64'd2);
    check("tmo_data", 64'(data_rd), 64'd0);

    // Timeout disabled: wait 1000 cycles, then ack
    start_z = 1'b1; address = 32'h480; write = 1'b0;
    tick();
    start_z = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      check("notmo_active", 64'(active_z), 64'd1);
      tick();
    end
    ack_z = 1'b1; wb_dat_i = 32'h55AA55AA;
    tick();
    ack_z = 1'b0;
    check("notmo_done", 64'(active_z), 64'd0);
    check("notmo_data", 64'(data_rd_z), 64'h55AA55AA);
    check("notmo_err", 64'(error_code_z), 64'd0);

    // Bus error
    req(32'h500, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    wb_err_i = 1'b1; wb_dat_i = 32'h77777777;
    tick();
    wb_err_i = 1'b0;
    check("err_code", 64'(error_code), 64'd1);
    check("err_data", 64'(data_rd), 64'd0);
    check("err_active", 64'(active), 64'd0);

    // ack and err together behave as ack
    req(32'h540, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    check("ackerr_start_clears_err", 64'(error_code), 64'd0);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h11112222;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check("ackerr_code", 64'(error_code), 64'd0);
    check("ackerr_data", 64'(data_rd), 64'h11112222);

    // start pulsed during ACCESS is ignored
    req(32'h600, 1'b0, 32'h0, 4'hF);
    tick();
    req(32'h700, 1'b1, 32'hAAAA, 4'h1);
    tick();
    start = 1'b0;
    check("ign_adr", 64'(wb_adr_o), 64'h600);
    check("ign_we", 64'(wb_we_o), 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h33334444;
    tick();
    wb_ack_i = 1'b0;
    check("ign_data", 64'(data_rd), 64'h33334444);
    for (int i = 0; i < 3; i++) begin
      check("ign_no_second_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
    end

    // Reset in the middle of a transfer
    req(32'h800, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    check("rstmid_active_before", 64'(active), 64'd1);
    wb_rst = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hBADBAD00;
    tick();
    wb_rst = 1'b0; wb_ack_i = 1'b0;
    check("rstmid_cyc", 64'(wb_cyc_o), 64'd0);
    check("rstmid_stb", 64'(wb_stb_o), 64'd0);
    check("rstmid_active", 64'(active), 64'd0);
    check("rstmid_err", 64'(error_code), 64'd0);
    check("rstmid_data", 64'(data_rd), 64'd0);
    req(32'h900, 1'b0, 32'h0, 4'hF);
    tick();
    start = 1'b0;
    check("post_rst_adr", 64'(wb_adr_o), 64'h900);
    wb_ack_i = 1'b1; wb_dat_i = 32'h00009999;
    tick();
    wb_ack_i = 1'b0;
    check("post_rst_active", 64'(active), 64'd0);
    check("post_rst_data", 64'(data_rd), 64'h9999);
    check("post_rst_err", 64'(error_code), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
